// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmit serializer between NUM_REQ
// byte-stream requesters, one packet per grant, with a stall watchdog.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 24,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_empty,
  input  logic                   tx_done,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  input  logic                   err_clear,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  // Handshake: requester i transfers a byte on any cycle where
  // req_valid[i] && req_ready[i]; req_ready is only raised for the owner in LOCKED.
  typedef enum logic [1:0] {IDLE, LOCKED, SEND} state_t;

  state_t               state, state_nx;
  logic [IDW-1:0]       rr_ptr, rr_ptr_nx, grant_nx, grant_inc;
  logic [IDW-1:0]       win_id, cand_id;
  logic                 win_found;
  int unsigned          arb_idx;
  logic [7:0]           data_nx;
  logic                 empty_nx, last_r, last_nx, err_nx, set_err;
  logic [TIMEOUT_W-1:0] wd, wd_nx;
  logic                 wd_on, wd_expire;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    arb_idx   = 0;
    cand_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = (32'(rr_ptr) + 32'(k)) % NUM_REQ;
      cand_id = IDW'(arb_idx);
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign grant_inc = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  assign wd_on     = (timeout_limit != '0);
  assign wd_expire = wd_on && (wd <= TIMEOUT_W'(1));

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    grant_nx  = grant_id;
    data_nx   = tx_data;
    empty_nx  = tx_empty;
    last_nx   = last_r;
    wd_nx     = wd;
    set_err   = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx = win_id;
          wd_nx    = timeout_limit;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[grant_id] = 1'b1;
        if (req_valid[grant_id]) begin
          data_nx  = req_data[{grant_id, 3'b000} +: 8];
          last_nx  = req_last[grant_id];
          empty_nx = 1'b0;
          wd_nx    = timeout_limit;
          state_nx = SEND;
        end else if (wd_expire) begin
          set_err   = 1'b1;
          rr_ptr_nx = grant_inc;
          state_nx  = IDLE;
        end else if (wd_on) begin
          wd_nx = wd - TIMEOUT_W'(1);
        end
      end
      SEND: begin
        // End of frame takes priority over a coincident watchdog expiry.
        if (tx_done) begin
          empty_nx = 1'b1;
          if (last_r) begin
            rr_ptr_nx = grant_inc;
            state_nx  = IDLE;
          end else begin
            wd_nx    = timeout_limit;
            state_nx = LOCKED;
          end
        end else if (wd_expire) begin
          set_err   = 1'b1;
          empty_nx  = 1'b1;
          rr_ptr_nx = grant_inc;
          state_nx  = IDLE;
        end else if (wd_on) begin
          wd_nx = wd - TIMEOUT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (set_err)        err_nx = 1'b1;
    else if (err_clear) err_nx = 1'b0;
    else                err_nx = timeout_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_empty    <= 1'b1;
      last_r      <= 1'b0;
      wd          <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_ptr_nx;
      grant_id    <= grant_nx;
      tx_data     <= data_nx;
      tx_empty    <= empty_nx;
      last_r      <= last_nx;
      wd          <= wd_nx;
      busy        <= (state_nx != IDLE);
      timeout_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester queues, a serializer model and a
// packet-level round-robin reference feeding an expected-byte queue.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_empty, tx_done, err_clear, busy, timeout_err;
  logic [23:0] timeout_limit;
  logic [1:0]  grant_id;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_W(24)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_empty(tx_empty),
    .tx_done(tx_done), .timeout_limit(timeout_limit), .err_clear(err_clear),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-requester byte queues: {last, byte}
  logic [8:0]  rbuf [N][16];
  int          rhead [N];
  int          rtail [N];
  logic [10:0] exp_q[$];
  logic [10:0] last_acc;
  int          model_ptr, ser_delay, ser_cnt, acc_cnt, fall_cnt;
  bit          ser_en, prev_empty, done_seen;

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] b, input logic last);
    rbuf[id][rtail[id]] = {last, b};
    rtail[id]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rhead[i] != rtail[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
        req_last[i]       = rbuf[i][rhead[i]][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // Packet-level round robin over whatever is queued now.
  task automatic build_expected();
    int h[N];
    int idx, win;
    bit found, done_pkt;
    for (int i = 0; i < N; i++) h[i] = rhead[i];
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      win = 0;
      for (int k = 0; k < N; k++) begin
        idx = (model_ptr + k) % N;
        if (!found && h[idx] != rtail[idx]) begin
          found = 1'b1;
          win = idx;
        end
      end
      if (found) begin
        do begin
          exp_q.push_back({3'(win), rbuf[win][h[win]][7:0]});
          done_pkt = rbuf[win][h[win]][8];
          h[win]++;
        end while (!done_pkt && h[win] != rtail[win]);
        model_ptr = (win + 1) % N;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; err_clear = 1'b0; timeout_limit = '0;
    clear_queues();
    exp_q.delete();
    model_ptr = 0; ser_cnt = 0; acc_cnt = 0; fall_cnt = 0;
    prev_empty = 1'b1; done_seen = 1'b0; last_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: capture handshakes before the edge, then score and drive after it.
  task automatic step();
    logic [N-1:0] hs;
    logic         done_pre;
    logic [10:0]  got;
    hs = req_valid & req_ready;
    done_pre = tx_done;
    @(posedge clk);
    #1;
    done_seen = done_pre;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        got = {3'(i), rbuf[i][rhead[i]][7:0]};
        rhead[i]++;
        acc_cnt++;
        last_acc = got;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL accept_order: got id=%0d byte=%02h, required no transfer", got[10:8], got[7:0]);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL accept_order: got id=%0d byte=%02h, required id=%0d byte=%02h",
                     got[10:8], got[7:0], exp_q[0][10:8], exp_q[0][7:0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    if (prev_empty && !tx_empty) begin
      fall_cnt++;
      checks++;
      if (tx_data !== last_acc[7:0] || 3'(grant_id) !== last_acc[10:8]) begin
        errors++;
        $display("FAIL stage: tx_data=%02h grant_id=%0d, required %02h/%0d",
                 tx_data, grant_id, last_acc[7:0], last_acc[10:8]);
      end
    end
    prev_empty = tx_empty;
    if (ser_en) begin
      if (tx_done) tx_done = 1'b0;
      else if (!tx_empty) begin
        ser_cnt++;
        if (ser_cnt >= ser_delay) begin
          ser_cnt = 0;
          checks++;
          if (tx_data !== last_acc[7:0]) begin
            errors++;
            $display("FAIL hold: tx_data=%02h at end of frame, required %02h", tx_data, last_acc[7:0]);
          end
          tx_done = 1'b1;
        end
      end
    end
    drive_reqs();
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(queues_empty() && exp_q.size() == 0 && !busy && tx_empty) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!(queues_empty() && exp_q.size() == 0 && !busy && tx_empty)) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles, pending=%0d busy=%0b, required drained and idle",
               name, budget, exp_q.size(), busy);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!done_seen && n < budget);
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s: no tx_done within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic wait_accept(input int count, input int budget, input string name);
    int n;
    n = 0;
    while (acc_cnt < count && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (acc_cnt < count) begin
      errors++;
      $display("FAIL %s: accepted=%0d, required %0d", name, acc_cnt, count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: %b, required 0000", req_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: %02h, required 00", tx_data); end
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: %b, required 1", tx_empty); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: %0d, required 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: %b, required 0", timeout_err); end
  endtask

  task automatic test_single_packet();
    do_reset();
    ser_en = 1'b1; ser_delay = 10;
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b1);
    build_expected();
    drive_reqs();
    step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL arb_latency: busy=%b grant=%0d ready=%b, required 1/2/0100", busy, grant_id, req_ready);
    end
    step();
    checks++;
    if (tx_empty !== 1'b0 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL accept_latency: empty=%b data=%02h, required 0/41", tx_empty, tx_data);
    end
    wait_done(30, "single_first_done");
    checks++;
    if (req_ready !== 4'b0100 || tx_empty !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_locked: ready=%b empty=%b busy=%b, required 0100/1/1", req_ready, tx_empty, busy);
    end
    step();
    checks++;
    if (tx_empty !== 1'b0 || tx_data !== 8'h42) begin
      errors++;
      $display("FAIL gap_accept: empty=%b data=%02h, required 0/42", tx_empty, tx_data);
    end
    wait_done(30, "single_last_done");
    checks++;
    if (busy !== 1'b0 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL packet_end: busy=%b empty=%b, required 0/1", busy, tx_empty);
    end
    run_until_idle(50, "single_packet");
    checks++;
    if (fall_cnt !== 2 || grant_id !== 2'd2 || tx_data !== 8'h42) begin
      errors++;
      $display("FAIL single_summary: falls=%0d grant=%0d data=%02h, required 2/2/42", fall_cnt, grant_id, tx_data);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    ser_en = 1'b1; ser_delay = 2;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_byte(i, 8'($urandom), 1'b1);
    build_expected();
    drive_reqs();
    run_until_idle(1000, "fairness");
  endtask

  task automatic test_no_preempt();
    do_reset();
    ser_en = 1'b1; ser_delay = 4;
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b0);
    push_byte(1, 8'h13, 1'b1);
    build_expected();
    drive_reqs();
    wait_accept(1, 20, "preempt_first");
    push_byte(0, 8'h5A, 1'b1);
    exp_q.push_back({3'd0, 8'h5A});
    drive_reqs();
    run_until_idle(500, "no_preempt");
  endtask

  task automatic test_random();
    do_reset();
    ser_en = 1'b1;
    for (int round = 0; round < 4; round++) begin
      ser_delay = $urandom_range(1, 6);
      timeout_limit = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom_range(40, 1000));
      clear_queues();
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), (b == len - 1));
        end
      end
      build_expected();
      drive_reqs();
      run_until_idle(3000, "random");
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL random_err: timeout_err=%b, required 0", timeout_err);
      end
    end
  endtask

  task automatic test_watchdog_send();
    do_reset();
    timeout_limit = 24'd50; ser_en = 1'b0;
    push_byte(1, 8'hC3, 1'b0);
    push_byte(1, 8'hC4, 1'b1);
    exp_q.push_back({3'd1, 8'hC3});
    drive_reqs();
    wait_accept(1, 20, "wd_send_accept");
    repeat (49) step();
    checks++;
    if (timeout_err !== 1'b0 || tx_empty !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_send_early: err=%b empty=%b busy=%b, required 0/0/1", timeout_err, tx_empty, busy);
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || tx_empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_send_expire: err=%b empty=%b busy=%b, required 1/1/0", timeout_err, tx_empty, busy);
    end
    clear_queues();
    drive_reqs();
    step();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: err=%b, required 1", timeout_err); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear: err=%b, required 0", timeout_err); end
    // Pointer moved past requester 1, so 2 goes first.
    ser_en = 1'b1; ser_delay = 3;
    push_byte(1, 8'hD1, 1'b1);
    push_byte(2, 8'hD2, 1'b1);
    model_ptr = 2;
    build_expected();
    drive_reqs();
    run_until_idle(200, "wd_send_after");
  endtask

  task automatic test_watchdog_locked();
    do_reset();
    timeout_limit = 24'd20; ser_en = 1'b1; ser_delay = 3;
    push_byte(1, 8'h77, 1'b0);
    exp_q.push_back({3'd1, 8'h77});
    drive_reqs();
    wait_done(50, "wd_locked_done");
    checks++;
    if (busy !== 1'b1 || req_ready !== 4'b0010 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL wd_locked_entry: busy=%b ready=%b empty=%b, required 1/0010/1", busy, req_ready, tx_empty);
    end
    repeat (19) step();
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_locked_early: busy=%b err=%b, required 1/0", busy, timeout_err);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_locked_expire: busy=%b err=%b, required 0/1", busy, timeout_err);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    timeout_limit = 24'd0;
    push_byte(3, 8'h99, 1'b0);
    exp_q.push_back({3'd3, 8'h99});
    drive_reqs();
    wait_done(50, "wd_off_done");
    repeat (300) step();
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || req_ready !== 4'b1000 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL wd_disabled: busy=%b err=%b ready=%b grant=%0d, required 1/0/1000/3",
               busy, timeout_err, req_ready, grant_id);
    end
  endtask

  task automatic test_done_vs_expiry();
    do_reset();
    timeout_limit = 24'd8; ser_en = 1'b0;
    push_byte(0, 8'hE1, 1'b1);
    exp_q.push_back({3'd0, 8'hE1});
    drive_reqs();
    wait_accept(1, 20, "coincide_accept");
    repeat (7) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL done_vs_expiry: err=%b busy=%b empty=%b, required 0/0/1", timeout_err, busy, tx_empty);
    end
  endtask

  task automatic test_reset_in_send();
    int n;
    do_reset();
    ser_en = 1'b1; ser_delay = 40;
    push_byte(3, 8'hA5, 1'b0);
    push_byte(3, 8'hA6, 1'b1);
    build_expected();
    drive_reqs();
    n = 0;
    while (tx_empty !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (tx_empty !== 1'b0) begin errors++; $display("FAIL reset_setup: empty=%b, required 0", tx_empty); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (tx_empty !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h00 ||
        req_ready !== 4'b0000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_send: empty=%b busy=%b grant=%0d data=%02h ready=%b err=%b, required 1/0/0/00/0000/0",
               tx_empty, busy, grant_id, tx_data, req_ready, timeout_err);
    end
    do_reset();
    ser_en = 1'b1; ser_delay = 2;
    push_byte(1, 8'h3C, 1'b1);
    push_byte(3, 8'h3D, 1'b1);
    build_expected();
    drive_reqs();
    run_until_idle(200, "after_reset");
  endtask

  initial begin
    ser_en = 1'b0;
    ser_delay = 1;
    test_reset();
    test_single_packet();
    test_fairness();
    test_no_preempt();
    test_random();
    test_watchdog_send();
    test_watchdog_locked();
    test_done_vs_expiry();
    test_reset_in_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares the single UART transmit serializer between `NUM_REQ` byte-stream requesters. It grants the serializer to one requester per packet, stages one byte at a time, and presents it on the serializer's `data`/`empty` inputs. It waits for the serializer's end-of-frame pulse before issuing the next byte. A programmable watchdog releases a stalled grant and flags an error. The block sits between the uC-side producers (console, debug, status streams) and the UART transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_W`, default 24: width of the watchdog counter and `timeout_limit`.
- `IDW`: derived, `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte of requester i ends its packet.
- `req_ready`  out  NUM_REQ  byte of requester i accepted this cycle when valid.
- `tx_data`  out  8  byte to serializer.
- `tx_empty`  out  1  low while a staged byte awaits transmission.
- `tx_done`  in  1  one-cycle pulse from serializer: staged byte fully sent (stop bits done).
- `timeout_limit`  in  TIMEOUT_W  watchdog reload in cycles; 0 disables the watchdog.
- `err_clear`  in  1  clears `timeout_err`.
- `grant_id`  out  IDW  current or last owner.
- `busy`  out  1  high in any state but IDLE.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- State machine: IDLE, LOCKED, SEND.
- **IDLE:**
  - If any `req_valid`, the winner is the first i with `req_valid[i]`, searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - Then `grant_id` <= winner, watchdog <= `timeout_limit`, go to LOCKED.
  - Otherwise stay in IDLE.
- **LOCKED:**
  - `req_ready[grant_id]` = 1, combinational; all other `req_ready` bits are 0.
  - On `req_valid[grant_id]`: `tx_data` <= byte, `last_r` <= `req_last[grant_id]`, `tx_empty` <= 0, watchdog <= `timeout_limit`, go to SEND.
  - Other requesters' `req_valid` are ignored for the whole packet; there is no preemption.
- **SEND:**
  - `tx_data` is held stable and `tx_empty` is held at 0 until `tx_done`.
  - On `tx_done`: `tx_empty` <= 1. If `last_r`, set `rr_ptr` <= (`grant_id`+1) mod NUM_REQ and go to IDLE. Otherwise reload the watchdog and go to LOCKED.
- **Watchdog:**
  - Active in LOCKED and SEND when `timeout_limit` != 0. It decrements each cycle.
  - On reaching 0 without the exit event, set `timeout_err` <= 1, `tx_empty` <= 1, advance `rr_ptr` as on release, and go to IDLE.
  - On timeout the rest of the packet is abandoned; the owner re-arbitrates normally.
- `tx_done` outside SEND is ignored.
- `timeout_err` is cleared only by `err_clear`. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - Outputs: `req_ready`=0, `tx_data`=0, `tx_empty`=1, `grant_id`=0, `busy`=0, `timeout_err`=0.
- Reset is honoured mid-operation. `tx_empty` returns to 1 asynchronously, and any in-flight packet is dropped.
- Arbitration latency: `req_valid` high in cycle 0 (IDLE) gives LOCKED in cycle 1. In cycle 1, `req_ready` is high and the byte is accepted at the end of cycle 1. `tx_empty`=0 in cycle 2.
- Inter-byte gap: `tx_done` in cycle k gives LOCKED in k+1 with `req_ready` high. If valid, the next byte is accepted in k+1 and `tx_empty`=0 in k+2.
- Packet boundary: `tx_done` on a last byte in cycle k gives IDLE in k+1 and arbitration in k+1. The next owner's `req_ready` is high in k+2.
- Exactly one byte is in flight at any time, so there is no buffering beyond the stage register.
- If `tx_done` and watchdog expiry coincide, `tx_done` wins and no error is flagged.
- `busy` and `grant_id` are registered and change on the state-transition edge.

## Test plan
- **Single packet:** req 2 sends 0x41, 0x42 (last on 0x42); serializer model returns `tx_done` 10 cycles after `tx_empty` falls. Required: `tx_data` 0x41 then 0x42, `grant_id`=2, `tx_empty` low twice, return to IDLE, `busy` low.
- **Fairness:** all 4 requesters hold continuous 1-byte packets. Required: grant order 0,1,2,3,0,…, and no requester is granted twice before the others.
- **No preemption:** req 1 starts a 3-byte packet; req 0 raises valid after the first byte. Required: all 3 req 1 bytes are sent first, then req 0.
- **Watchdog in SEND:** `timeout_limit`=50, `tx_done` never comes. Required: `timeout_err`=1 exactly 50 cycles after acceptance, `tx_empty`=1, IDLE, `rr_ptr` advanced. `err_clear` then clears the flag.
- **Watchdog in LOCKED:** owner drops valid mid-packet with `timeout_limit`=20. Required: grant released after 20 cycles with `timeout_err`=1. With `timeout_limit`=0, the grant is held indefinitely.
- **Edge cases:**
  - Assert reset during SEND: `tx_empty`=1 immediately and all outputs return to reset values.
  - `tx_done` coincident with expiry: no error is flagged.
